// File: rtl/qsfp_led_pkg.sv
// qsfp_led_pkg: shared field offsets, ctrlport status codes and register address for the QSFP LED driver
package qsfp_led_pkg;
    localparam int Q0_LINK = 0;
    localparam int Q0_ACT  = 4;
    localparam int Q1_LINK = 8;
    localparam int Q1_ACT  = 12;
    typedef enum logic [1:0] {
        STS_OKAY   = 2'b00,
        STS_CMDERR = 2'b01,
        STS_TSERR  = 2'b10,
        STS_SLVERR = 2'b11
    } ctrlport_status_t;
    localparam logic [19:0] LED_REG_ADDR = 20'd0;
endpackage

// File: rtl/qsfp_led_blinker.sv
// qsfp_led_blinker: blink phase generator with per-lane activity stretch
module qsfp_led_blinker #(
    parameter int BLINK_HALF_PERIOD = 2500000,
    parameter int STRETCH_PERIODS   = 3
) (
    input  logic       ctrlport_clk,
    input  logic       ctrlport_rst,
    input  logic [7:0] act,
    output logic [7:0] act_lit
);
    localparam int CW = $clog2(BLINK_HALF_PERIOD);
    logic [CW-1:0] cnt;
    logic          phase;
    logic          wrap;
    logic          tick;
    logic [3:0]    stretch [8];
    assign wrap = cnt == CW'(BLINK_HALF_PERIOD - 1);
    // a period ends when the lit half-phase wraps back to dark
    assign tick = wrap & phase;
    always_ff @(posedge ctrlport_clk) begin
        if (ctrlport_rst) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            phase <= phase ^ wrap;
        end
    end
    for (genvar i = 0; i < 8; i++) begin : g_lane
        always_ff @(posedge ctrlport_clk) begin
            if (ctrlport_rst)
                stretch[i] <= 4'd0;
            else
                stretch[i] <= act[i] ? 4'(STRETCH_PERIODS) :
                              (tick && stretch[i] != 4'd0) ? stretch[i] - 4'd1 : stretch[i];
        end
        assign act_lit[i] = (act[i] | (stretch[i] != 4'd0)) & phase;
    end
endmodule

// File: rtl/qsfp_led_driver.sv
// qsfp_led_driver: ctrlport LED register decode and registered front-panel QSFP LED pins
module qsfp_led_driver
    import qsfp_led_pkg::*;
#(
    parameter logic [19:0] LED_REGISTER_ADDRESS = LED_REG_ADDR,
    parameter int          BLINK_HALF_PERIOD    = 2500000,
    parameter int          STRETCH_PERIODS      = 3,
    parameter bit          LED_ACTIVE_LOW       = 1'b1
) (
    input  logic        ctrlport_clk,
    input  logic        ctrlport_rst,
    input  logic        s_ctrlport_req_wr,
    input  logic        s_ctrlport_req_rd,
    input  logic [19:0] s_ctrlport_req_addr,
    input  logic [31:0] s_ctrlport_req_data,
    input  logic [3:0]  s_ctrlport_req_byte_en,
    output logic        s_ctrlport_resp_ack,
    output logic [1:0]  s_ctrlport_resp_status,
    output logic [31:0] s_ctrlport_resp_data,
    output logic [3:0]  qsfp0_led_link,
    output logic [3:0]  qsfp0_led_active,
    output logic [3:0]  qsfp1_led_link,
    output logic [3:0]  qsfp1_led_active
);
    localparam logic [3:0] POL = {4{LED_ACTIVE_LOW}};
    logic [15:0] led_reg;
    logic        ack_r;
    logic [31:0] data_r;
    logic        hit;
    logic        wr_hit;
    logic        rd_hit;
    logic [7:0]  act_lit;
    logic        unused;
    assign hit    = s_ctrlport_req_addr == LED_REGISTER_ADDRESS;
    assign wr_hit = s_ctrlport_req_wr & hit;
    assign rd_hit = s_ctrlport_req_rd & hit;
    assign unused = ^{s_ctrlport_req_byte_en[3:2], s_ctrlport_req_data[31:16]};
    qsfp_led_blinker #(
        .BLINK_HALF_PERIOD(BLINK_HALF_PERIOD),
        .STRETCH_PERIODS  (STRETCH_PERIODS)
    ) u_blinker (
        .ctrlport_clk(ctrlport_clk),
        .ctrlport_rst(ctrlport_rst),
        .act         ({led_reg[Q1_ACT +: 4], led_reg[Q0_ACT +: 4]}),
        .act_lit     (act_lit)
    );
    always_ff @(posedge ctrlport_clk) begin
        if (ctrlport_rst) begin
            led_reg          <= 16'd0;
            ack_r            <= 1'b0;
            data_r           <= 32'd0;
            qsfp0_led_link   <= POL;
            qsfp0_led_active <= POL;
            qsfp1_led_link   <= POL;
            qsfp1_led_active <= POL;
        end else begin
            ack_r  <= wr_hit | rd_hit;
            data_r <= rd_hit ? {16'd0, led_reg} : 32'd0;
            if (wr_hit && s_ctrlport_req_byte_en[0]) led_reg[7:0]  <= s_ctrlport_req_data[7:0];
            if (wr_hit && s_ctrlport_req_byte_en[1]) led_reg[15:8] <= s_ctrlport_req_data[15:8];
            qsfp0_led_link   <= led_reg[Q0_LINK +: 4] ^ POL;
            qsfp0_led_active <= act_lit[3:0] ^ POL;
            qsfp1_led_link   <= led_reg[Q1_LINK +: 4] ^ POL;
            qsfp1_led_active <= act_lit[7:4] ^ POL;
        end
    end
    // a response pending when reset arrives is never presented
    assign s_ctrlport_resp_ack    = ack_r & ~ctrlport_rst;
    assign s_ctrlport_resp_data   = data_r & {32{~ctrlport_rst}};
    assign s_ctrlport_resp_status = STS_OKAY;
endmodule

// File: tb/tb_qsfp_led_driver.sv
// tb_qsfp_led_driver: table-driven, directed and random checks against a cycle-level reference model
module tb_qsfp_led_driver;
    localparam int H = 4;
    localparam int S = 2;
    logic        clk = 1'b0;
    logic        rst, wr, rd;
    logic [19:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        ack;
    logic [1:0]  status;
    logic [31:0] rdata;
    logic [3:0]  q0_link, q0_act, q1_link, q1_act;
    int vectors = 0;
    int miscompares = 0;
    logic [15:0] m_reg;
    int          m_t;
    int          m_str [8];
    logic        m_ack;
    logic [31:0] m_data;
    logic [15:0] m_pins;
    typedef struct {
        logic        wr;
        logic        rd;
        logic [19:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_ack;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl [12];
    always #5 clk = ~clk;
    qsfp_led_driver #(
        .LED_REGISTER_ADDRESS(20'd0),
        .BLINK_HALF_PERIOD   (H),
        .STRETCH_PERIODS     (S),
        .LED_ACTIVE_LOW      (1'b1)
    ) dut (
        .ctrlport_clk          (clk),
        .ctrlport_rst          (rst),
        .s_ctrlport_req_wr     (wr),
        .s_ctrlport_req_rd     (rd),
        .s_ctrlport_req_addr   (addr),
        .s_ctrlport_req_data   (data),
        .s_ctrlport_req_byte_en(be),
        .s_ctrlport_resp_ack   (ack),
        .s_ctrlport_resp_status(status),
        .s_ctrlport_resp_data  (rdata),
        .qsfp0_led_link        (q0_link),
        .qsfp0_led_active      (q0_act),
        .qsfp1_led_link        (q1_link),
        .qsfp1_led_active      (q1_act)
    );
    // lane l activity bit: lanes 0..3 at bits 4..7, lanes 4..7 at bits 12..15
    function automatic int act_idx(int l);
        return (l < 4) ? 4 + l : 8 + l;
    endfunction
    task automatic model_edge();
        int ph;
        bit tick;
        bit hit;
        logic [15:0] lit;
        if (rst) begin
            m_reg = 16'd0; m_t = 0; m_ack = 1'b0; m_data = 32'd0; m_pins = 16'hFFFF;
            for (int l = 0; l < 8; l++) m_str[l] = 0;
        end else begin
            ph   = (m_t / H) % 2;
            tick = (m_t % (2 * H)) == (2 * H - 1);
            hit  = addr == 20'd0;
            lit  = m_reg & 16'h0F0F;
            for (int l = 0; l < 8; l++)
                lit[act_idx(l)] = (m_reg[act_idx(l)] || m_str[l] > 0) && ph == 1;
            m_pins = ~lit;
            m_ack  = (wr || rd) && hit;
            m_data = (rd && hit) ? {16'd0, m_reg} : 32'd0;
            for (int l = 0; l < 8; l++)
                m_str[l] = m_reg[act_idx(l)] ? S : ((tick && m_str[l] > 0) ? m_str[l] - 1 : m_str[l]);
            if (wr && hit && be[0]) m_reg[7:0]  = data[7:0];
            if (wr && hit && be[1]) m_reg[15:8] = data[15:8];
            m_t++;
        end
    endtask
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask
    task automatic compare_all();
        check("pins", {16'd0, q1_act, q1_link, q0_act, q0_link}, {16'd0, m_pins});
        check("ack", {31'd0, ack}, {31'd0, m_ack & ~rst});
        check("status", {30'd0, status}, 32'd0);
        check("rdata", rdata, rst ? 32'd0 : m_data);
    endtask
    task automatic drive(input logic r, input logic w, input logic rd_i, input logic [19:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        rst = r; wr = w; rd = rd_i; addr = a; data = d; be = b;
    endtask
    task automatic tick_edge();
        @(posedge clk);
        #1;
        model_edge();
    endtask
    task automatic step(input logic r, input logic w, input logic rd_i, input logic [19:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        drive(r, w, rd_i, a, d, b);
        tick_edge();
        compare_all();
    endtask
    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 20'd0, 32'd0, 4'd0);
    endtask
    initial begin
        int lit_cnt;
        tbl[0]  = '{1'b1, 1'b0, 20'd0, 32'h0000_FFFF, 4'b0001, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 20'd0, 32'h0,         4'b0000, 1'b1, 32'h0000_00FF};
        tbl[2]  = '{1'b1, 1'b0, 20'd1, 32'h0000_ABCD, 4'b0011, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 20'd0, 32'h0,         4'b0000, 1'b1, 32'h0000_00FF};
        tbl[4]  = '{1'b1, 1'b1, 20'd0, 32'h0000_1234, 4'b0011, 1'b1, 32'h0000_00FF};
        tbl[5]  = '{1'b1, 1'b0, 20'd0, 32'h0000_5555, 4'b0010, 1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 20'd0, 32'h0000_AAAA, 4'b1100, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 20'd0, 32'h0,         4'b0000, 1'b1, 32'h0000_5534};
        tbl[8]  = '{1'b0, 1'b0, 20'd0, 32'h0,         4'b0000, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 20'h80000, 32'h0,     4'b0000, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 20'd0, 32'hFFFF_0F03, 4'b1111, 1'b1, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 20'd0, 32'h0,         4'b0000, 1'b1, 32'h0000_0F03};
        // reset state and quiet bus
        step(1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 4'd0);
        check("reset_pins", {16'd0, q1_act, q1_link, q0_act, q0_link}, 32'h0000_FFFF);
        for (int k = 0; k < 6; k++) idle();
        // link steady, activity blinking with the phase
        step(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_0F03, 4'b0011);
        check("wr_ack", {31'd0, ack}, 32'd1);
        idle();
        check("q0_link", {28'd0, q0_link}, 32'hC);
        for (int k = 0; k < 16; k++) idle();
        // table of single-cycle transactions from a fresh reset
        step(1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 4'd0);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, tbl[k].wr, tbl[k].rd, tbl[k].addr, tbl[k].data, tbl[k].be);
            check($sformatf("tbl%0d_ack", k), {31'd0, ack}, {31'd0, tbl[k].exp_ack});
            check($sformatf("tbl%0d_data", k), rdata, tbl[k].exp_data);
        end
        // back-to-back writes then readback
        step(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_0011, 4'b0011);
        check("b2b0_ack", {31'd0, ack}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_0022, 4'b0011);
        check("b2b1_ack", {31'd0, ack}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_0033, 4'b0011);
        check("b2b2_ack", {31'd0, ack}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 20'd0, 32'd0, 4'd0);
        check("b2b_rd", rdata, 32'h0000_0033);
        // stretch: clear activity at the start of a dark phase
        step(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_0010, 4'b0001);
        for (int k = 0; k < 3; k++) idle();
        for (int k = 0; k < 8 && (m_t % 8) != 0; k++) idle();
        step(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_0000, 4'b0001);
        lit_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            if (q0_act[0] == 1'b0) lit_cnt++;
        end
        check("stretch_lit", lit_cnt, 32'd8);
        check("stretch_end", {31'd0, q0_act[0]}, 32'd1);
        // reset the cycle after a write: ack never appears
        drive(1'b0, 1'b1, 1'b0, 20'd0, 32'h0000_FFFF, 4'b0011);
        tick_edge();
        drive(1'b1, 1'b0, 1'b0, 20'd0, 32'd0, 4'd0);
        #1;
        compare_all();
        check("rst_ack0", {31'd0, ack}, 32'd0);
        tick_edge();
        compare_all();
        check("rst_pins", {16'd0, q1_act, q1_link, q0_act, q0_link}, 32'h0000_FFFF);
        for (int k = 0; k < 3; k++) begin
            idle();
            check("rst_ack", {31'd0, ack}, 32'd0);
        end
        step(1'b0, 1'b0, 1'b1, 20'd0, 32'd0, 4'd0);
        check("rst_rd", rdata, 32'd0);
        // randomized traffic with rare resets
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 99) < 2, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 3)) : 20'd0,
                 $urandom, 4'($urandom_range(0, 15)));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
